// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - handshake and result bundle for bin_to_bcd_seq (blank_o with BIN_TO_BCD_BLANK_EN)
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start_i;
  logic [BIN_W-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  ovf_o;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_o;
`endif

`ifdef BIN_TO_BCD_BLANK_EN
  modport master (output start_i, bin_i, input busy_o, done_o, bcd_o, ovf_o, blank_o);
  modport slave  (input start_i, bin_i, output busy_o, done_o, bcd_o, ovf_o, blank_o);
`else
  modport master (output start_i, bin_i, input busy_o, done_o, bcd_o, ovf_o);
  modport slave  (input start_i, bin_i, output busy_o, done_o, bcd_o, ovf_o);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter (blank mask with BIN_TO_BCD_BLANK_EN)
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic              clk_i,
  input logic              rst_ni,
  bin_to_bcd_seq_if.slave  bus
);

  // Digits needed to hold any BIN_W-bit value; the accumulator keeps at least
  // one guard digit above DIGITS so every overflowing input is detected.
  localparam int FULL_D = (BIN_W * 301) / 1000 + 1;
  localparam int ACC_D  = (FULL_D > DIGITS + 1) ? FULL_D : DIGITS + 1;
  localparam int ACC_W  = 4 * ACC_D;
  localparam int CNT_W  = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    sh_q;
  logic [ACC_W-1:0]    acc_q, acc_adj, acc_nx;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_shift, start_ok, busy, done;
  logic                ovf_nx, ovf_q;
  logic [4*DIGITS-1:0] bcd_nx, bcd_q;

  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(BIN_W - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, start acceptance and status outputs
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = SHIFT;
          start_ok = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start_i) begin
          state_d  = SHIFT;
          start_ok = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next binary bit
  always_comb begin
    acc_adj = '0;
    for (int k = 0; k < ACC_D; k++) begin
      acc_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    end
    acc_nx = (acc_adj << 1) | ACC_W'(sh_q[BIN_W-1]);
    ovf_nx = |acc_nx[ACC_W-1:4*DIGITS];
    bcd_nx = ovf_nx ? {DIGITS{4'h9}} : acc_nx[4*DIGITS-1:0];
  end

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nx, blank_q;
  logic              all_zero;

  // Leading-zero mask from the top digit down; the units digit always stays lit
  always_comb begin
    blank_nx = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero    = all_zero & (acc_nx[4*k +: 4] == 4'd0);
      blank_nx[k] = all_zero & ~ovf_nx;
    end
  end

  // Blank mask is updated together with the BCD result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         blank_q <= '0;
    else if (last_shift) blank_q <= blank_nx;
  end

  assign bus.blank_o = blank_q;
`endif

  // Shift register, accumulator and bit counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_ok) begin
      sh_q  <= bus.bin_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      sh_q  <= sh_q << 1;
      acc_q <= acc_nx;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers hold until the next conversion finishes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last_shift) begin
      bcd_q <= bcd_nx;
      ovf_q <= ovf_nx;
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.bcd_o  = bcd_q;
  assign bus.ovf_o  = ovf_q;

endmodule
